// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// layer_sequencer
//   Broadcasts one input vector to a fully-connected layer, captures each
//   neuron's result pulse and streams the results downstream.
//   Revision: 1.0
// ============================================================================
module layer_sequencer #(
  parameter int numNeuron     = 30,
  parameter int numInput      = 784,
  parameter int dataWidth     = 16,
  parameter int timeoutCycles = 1023
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [dataWidth-1:0]           in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [dataWidth-1:0]           nrn_data,
  output logic                           nrn_valid,
  input  logic [numNeuron*dataWidth-1:0] nrn_out,
  input  logic [numNeuron-1:0]           nrn_outvalid,
  output logic [dataWidth-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done,
  output logic                           err_timeout
);

  localparam int ICW = $clog2(numInput + 1);
  localparam int WCW = $clog2(timeoutCycles + 1);
  localparam int IXW = $clog2(numNeuron + 1);
  localparam logic [ICW-1:0] IN_LAST   = ICW'(numInput - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(timeoutCycles - 1);
  localparam logic [IXW-1:0] IDX_LAST  = IXW'(numNeuron - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ICW-1:0]         in_cnt_q, in_cnt_d;
  logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [IXW-1:0]         idx_q, idx_d;
  logic [numNeuron-1:0]   flag_q, flag_d;
  logic [dataWidth-1:0]   hold_q [numNeuron];
  logic [dataWidth-1:0]   hold_d [numNeuron];
  logic [dataWidth-1:0]   nrn_data_q, nrn_data_d;
  logic                   nrn_valid_q, nrn_valid_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    idx_d       = idx_q;
    flag_d      = flag_q;
    hold_d      = hold_q;
    nrn_data_d  = nrn_data_q;
    nrn_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;

    // Capture runs first so the WAIT exit test sees this cycle's pulses.
    if (state_q == S_FEED || state_q == S_WAIT) begin
      for (int k = 0; k < numNeuron; k++) begin
        if (nrn_outvalid[k]) begin
          hold_d[k] = nrn_out[k*dataWidth +: dataWidth];
          flag_d[k] = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FEED;
          in_cnt_d = '0;
          idx_d    = '0;
          flag_d   = '0;
          err_d    = 1'b0;
          for (int k = 0; k < numNeuron; k++) hold_d[k] = '0;
        end
      end
      S_FEED: begin
        if (in_valid) begin
          nrn_data_d  = in_data;
          nrn_valid_d = 1'b1;
          in_cnt_d    = in_cnt_q + ICW'(1);
          if (in_cnt_q == IN_LAST) begin
            state_d    = S_WAIT;
            wait_cnt_d = '0;
          end
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + WCW'(1);
        if (&flag_d) begin
          state_d = S_DRAIN;
          idx_d   = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
          idx_d   = '0;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IXW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt_q    <= '0;
      wait_cnt_q  <= '0;
      idx_q       <= '0;
      flag_q      <= '0;
      nrn_data_q  <= '0;
      nrn_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int k = 0; k < numNeuron; k++) hold_q[k] <= '0;
    end else begin
      in_cnt_q    <= in_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      idx_q       <= idx_d;
      flag_q      <= flag_d;
      nrn_data_q  <= nrn_data_d;
      nrn_valid_q <= nrn_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      for (int k = 0; k < numNeuron; k++) hold_q[k] <= hold_d[k];
    end
  end

  // Mux by compare so the index never reaches past the last holding register.
  always_comb begin
    out_data = '0;
    if (state_q == S_DRAIN) begin
      for (int k = 0; k < numNeuron; k++) begin
        if (idx_q == IXW'(k)) out_data = hold_q[k];
      end
    end
  end

  assign in_ready    = (state_q == S_FEED);
  assign out_valid   = (state_q == S_DRAIN);
  assign out_last    = (state_q == S_DRAIN) && (idx_q == IDX_LAST);
  assign busy        = (state_q != S_IDLE);
  assign nrn_data    = nrn_data_q;
  assign nrn_valid   = nrn_valid_q;
  assign done        = done_q;
  assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
// tb_layer_sequencer
//   Directed bench: basic, gapped/staggered, timeout, backpressure, reset.
//   Revision: 1.0
// ============================================================================
module tb_layer_sequencer;
  localparam int NN = 4;
  localparam int NI = 8;
  localparam int DW = 16;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     nrn_data;
  logic              nrn_valid;
  logic [NN*DW-1:0]  nrn_out = '0;
  logic [NN-1:0]     nrn_outvalid = '0;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              err_timeout;

  int checks = 0;
  int failures = 0;

  layer_sequencer #(
    .numNeuron(NN), .numInput(NI), .dataWidth(DW), .timeoutCycles(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .nrn_data(nrn_data), .nrn_valid(nrn_valid),
    .nrn_out(nrn_out), .nrn_outvalid(nrn_outvalid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NN-1:0] mask, input logic [NN*DW-1:0] vals);
    nrn_outvalid = mask;
    nrn_out      = vals;
    step();
    nrn_outvalid = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_in_ready", 32'(in_ready), 32'd1);
    check("start_err_clear", 32'(err_timeout), 32'd0);
  endtask

  task automatic feed(input bit gapped, input logic [DW-1:0] base);
    logic [DW-1:0] v;
    for (int i = 0; i < NI; i++) begin
      v        = base + DW'(i);
      in_valid = 1'b1;
      in_data  = v;
      step();
      in_valid = 1'b0;
      in_data  = 16'hDEAD;
      check("feed_nrn_valid", 32'(nrn_valid), 32'd1);
      check("feed_nrn_data", 32'(nrn_data), 32'(v));
      check("feed_in_ready", 32'(in_ready), 32'(i != NI - 1));
      if (gapped || i == NI - 1) begin
        step();
        check("gap_nrn_valid", 32'(nrn_valid), 32'd0);
        check("gap_in_ready", 32'(in_ready), 32'(i != NI - 1));
      end
    end
  endtask

  task automatic drain(input logic [NN*DW-1:0] exp, input int stall_idx);
    logic [DW-1:0] v;
    check("drain_entry", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int j = 0; j < NN; j++) begin
      v = exp[j*DW +: DW];
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_data", 32'(out_data), 32'(v));
      check("drain_last", 32'(out_last), 32'(j == NN - 1));
      check("drain_done_low", 32'(done), 32'd0);
      if (j == stall_idx) begin
        // Stray start and neuron pulses during the stall must be ignored.
        out_ready    = 1'b0;
        start        = 1'b1;
        nrn_outvalid = '1;
        nrn_out      = {NN{16'hBEEF}};
        for (int s = 0; s < 5; s++) begin
          step();
          start        = 1'b0;
          nrn_outvalid = '0;
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", 32'(out_data), 32'(v));
          check("stall_last", 32'(out_last), 32'(j == NN - 1));
        end
        out_ready = 1'b1;
      end
      step();
    end
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy_low", 32'(busy), 32'd0);
    check("done_out_valid_low", 32'(out_valid), 32'd0);
    step();
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_nrn_valid", 32'(nrn_valid), 32'd0);
    check("rst_nrn_data", 32'(nrn_data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    rst = 1'b0;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Basic pass
    do_start();
    feed(1'b0, 16'h0001);
    pulse(4'hF, {16'h0400, 16'h0300, 16'h0200, 16'h0100});
    drain({16'h0400, 16'h0300, 16'h0200, 16'h0100}, -1);

    // Gapped input with staggered capture; neuron 0 pulses twice
    do_start();
    feed(1'b1, 16'h0011);
    pulse(4'b0100, {16'h0000, 16'h2222, 16'h0000, 16'h0000});
    check("stag_wait_a", 32'(out_valid), 32'd0);
    pulse(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'hAAAA});
    check("stag_wait_b", 32'(out_valid), 32'd0);
    pulse(4'b1000, {16'h4444, 16'h0000, 16'h0000, 16'h0000});
    check("stag_wait_c", 32'(out_valid), 32'd0);
    pulse(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h1111});
    check("stag_wait_d", 32'(out_valid), 32'd0);
    step();
    check("stag_wait_e", 32'(out_valid), 32'd0);
    pulse(4'b0010, {16'h0000, 16'h0000, 16'h3333, 16'h0000});
    drain({16'h4444, 16'h2222, 16'h3333, 16'h1111}, -1);

    // Timeout: neuron 3 never pulses, its hold from the last pass is cleared
    do_start();
    feed(1'b0, 16'h0100);
    pulse(4'b0111, {16'hFFFF, 16'h0C0C, 16'h0B0B, 16'h0A0A});
    for (int c = 0; c < 13; c++) begin
      step();
      check("to_still_waiting", 32'(out_valid), 32'd0);
      check("to_err_low", 32'(err_timeout), 32'd0);
    end
    step();
    check("to_err_set", 32'(err_timeout), 32'd1);
    drain({16'h0000, 16'h0C0C, 16'h0B0B, 16'h0A0A}, -1);
    check("to_err_sticky", 32'(err_timeout), 32'd1);

    // Backpressure at idx 1; the start here also clears err_timeout
    do_start();
    feed(1'b0, 16'h0200);
    pulse(4'hF, {16'h0D04, 16'h0D03, 16'h0D02, 16'h0D01});
    drain({16'h0D04, 16'h0D03, 16'h0D02, 16'h0D01}, 1);

    // Reset mid-FEED, then a fresh pass
    do_start();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0050 + DW'(i);
      step();
    end
    in_valid = 1'b0;
    check("midrst_pre_nrn_valid", 32'(nrn_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_nrn_valid", 32'(nrn_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    step();
    check("midrst_no_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();
    check("midrst_idle", 32'(busy), 32'd0);
    check("midrst_no_done2", 32'(done), 32'd0);
    do_start();
    feed(1'b0, 16'h0031);
    pulse(4'hF, {16'h0E04, 16'h0E03, 16'h0E02, 16'h0E01});
    drain({16'h0E04, 16'h0E03, 16'h0E02, 16'h0E01}, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Sequences one fully-connected layer of neurons through one pass.
- Accepts an input vector from an upstream stream and broadcasts it one element per cycle to every neuron of the layer, on the neurons' shared input-data and input-valid lines.
- Collects each neuron's one-cycle result pulse into a holding register.
- Serializes the layer's results downstream with a valid/ready handshake.
- Sits between the layer's neuron array and the next layer or the output buffer.

Parameters:
numNeuron, 30, neurons in the layer (>=1)
numInput, 784, input elements per pass; must equal each neuron's weight count (>=1)
dataWidth, 16, data word width
timeoutCycles, 1023, maximum cycles allowed in WAIT before abort (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a pass
in_data  in  dataWidth  upstream input element
in_valid  in  1  upstream element valid
in_ready  out  1  sequencer accepts in_data this cycle
nrn_data  out  dataWidth  broadcast input to all neurons
nrn_valid  out  1  broadcast input valid to all neurons
nrn_out  in  numNeuron*dataWidth  neuron results; neuron k at bits [k*dataWidth +: dataWidth]
nrn_outvalid  in  numNeuron  per-neuron one-cycle result pulse
out_data  out  dataWidth  serialized result
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts
out_last  out  1  marks result numNeuron-1
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after the last result transfers
err_timeout  out  1  sticky; set on WAIT timeout; cleared by rst or by the next accepted start

Behaviour:
- Reset: all outputs are 0; state IDLE; all counters, capture flags and holding registers are 0.
- States: IDLE, FEED, WAIT, DRAIN.
- IDLE:
  - start=1 -> FEED. On this transition: clear in_cnt, all capture flags and all holding registers; clear err_timeout.
  - start in any other state is ignored.
- FEED:
  - in_ready=1 only in FEED.
  - Accept when in_valid & in_ready. nrn_data<=in_data and nrn_valid<=1 on the next edge (1-cycle latency).
  - nrn_valid=0 on any cycle without an accept. Gaps are allowed; order is preserved.
  - in_cnt increments on each accept. The accept that makes in_cnt==numInput moves to WAIT, and in_ready drops in that same edge.
- Capture (FEED and WAIT only):
  - nrn_outvalid[k]=1 loads hold[k]<=nrn_out slice k and sets flag[k].
  - A repeat pulse for neuron k overwrites hold[k].
  - Pulses in IDLE and DRAIN are ignored.
- WAIT:
  - wait_cnt clears on entry and increments every cycle.
  - All flags set (including any set in the current cycle) -> DRAIN.
  - Otherwise wait_cnt==timeoutCycles-1 -> set err_timeout, go to DRAIN. Uncaptured holds stay 0.
- DRAIN:
  - Index idx runs from 0 to numNeuron-1. out_valid=1 and out_data=hold[idx]; out_last=(idx==numNeuron-1).
  - Transfer occurs on out_valid & out_ready; idx increments.
  - out_data is held stable while out_valid & !out_ready.
  - Last transfer: done=1 on the next cycle, state goes to IDLE, out_valid drops.
- Reset mid-pass (any state): immediate return to IDLE and all outputs 0, with no done pulse.
- numNeuron=1: a single transfer with out_last=1.
- Counter widths:
  - in_cnt: $clog2(numInput+1)
  - wait_cnt: $clog2(timeoutCycles+1)
  - idx: $clog2(numNeuron+1)
  - None of these counters wraps.

Test Plan (numNeuron=4, numInput=8, dataWidth=16, timeoutCycles=16):
- Basic pass:
  - Stimulus: start, then 8 back-to-back inputs 0x0001..0x0008; all 4 nrn_outvalid pulse together with 0x0100,0x0200,0x0300,0x0400; out_ready=1.
  - Response: nrn_valid high for exactly 8 cycles, each one cycle after its accept; out_data 0x0100..0x0400 in order; out_last on the 4th; done one cycle later; busy low afterward.
- Gapped input:
  - Stimulus: in_valid toggles 1,0,1,0 across the 8 elements.
  - Response: nrn_valid mirrors each accept with 1-cycle delay; exactly 8 nrn_valid cycles; in_ready=0 after the 8th accept.
- Staggered capture:
  - Stimulus: pulses for neurons 2,0,3 on different cycles, then neuron 1 three cycles later.
  - Response: DRAIN entered only after neuron 1; all four values correct.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles during DRAIN at idx 1.
  - Response: out_valid=1 and out_data=hold[1] stable throughout; no skip or duplicate; done after 4 transfers.
- Timeout:
  - Stimulus: neuron 3 never pulses.
  - Response: err_timeout=1 after 16 WAIT cycles; result 3 reads 0x0000; done pulses; the next start clears err_timeout.
- Reset mid-FEED:
  - Stimulus: assert rst after the 3rd input.
  - Response: in_ready, nrn_valid, busy and out_valid are 0 immediately; no done; a fresh start runs a full correct pass.
